// File: rtl/ysyx_22041752_pkg.sv
// ysyx_22041752_pkg: shared widths and the write-back entry type
package ysyx_22041752_pkg;
  localparam int XLEN   = 64;
  localparam int GPR_AW = 5;
  localparam int NGPR   = 32;
  typedef struct packed {
    logic [GPR_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/ysyx_22041752_wb_fifo.sv
// ysyx_22041752_wb_fifo: synchronous FIFO of write-back entries (EXU skid buffer)
// Ports: push/din write an entry when not full; pop retires head when not empty;
//        full/empty flags; head is the oldest entry.
module ysyx_22041752_wb_fifo
  import ysyx_22041752_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);
  // Pointers carry one wrap bit above the index; full is judged by distance, so DEPTH=1 also works.
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] ONE = 1;
  localparam logic [AW:0] CAP = DEPTH;
  wb_entry_t   mem [2**AW];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full  = (wp - rp) == CAP;
  assign head  = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + ONE;
      if (pop && !empty) rp <= rp + ONE;
    end
  end
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/ysyx_22041752_wb_arbiter.sv
// ysyx_22041752_wb_arbiter: merges EXU and LSU results onto the regfile write port, tracks in-flight loads
// Ports: exu_* valid/ready result stream; lsu_* always-accepted load results;
//        ld_issue/ld_issue_rd mark a load target busy; rf_* registered regfile write port;
//        busy is the per-GPR load scoreboard.
module ysyx_22041752_wb_arbiter
#(
  parameter int XLEN       = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic            exu_wen,
  input  logic [4:0]      exu_rd,
  input  logic [XLEN-1:0] exu_data,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            ld_issue,
  input  logic [4:0]      ld_issue_rd,
  output logic            rf_we,
  output logic [4:0]      rf_addr_w,
  output logic [XLEN-1:0] rf_data_w,
  output logic [31:0]     busy
);
  import ysyx_22041752_pkg::*;
  localparam logic [NGPR-1:0] BIT0 = 1;
  wb_entry_t       head, win, exu_ent;
  logic            full, empty, take, sel, push, pop;
  logic [NGPR-1:0] set_v, clr_v, busy_nxt;
  assign exu_ready = !full;
  assign exu_ent   = wb_entry_t'{rd: exu_rd, data: exu_data};
  always_comb begin
    take     = exu_valid && !full && exu_wen;
    sel      = lsu_valid || !empty || take;
    win      = lsu_valid ? wb_entry_t'{rd: lsu_rd, data: lsu_data} : !empty ? head : exu_ent;
    pop      = !lsu_valid && !empty;
    push     = take && (lsu_valid || !empty);
    clr_v    = lsu_valid ? BIT0 << lsu_rd : '0;
    set_v    = ld_issue ? BIT0 << ld_issue_rd : '0;
    busy_nxt = ((busy & ~clr_v) | set_v) & ~BIT0;
  end
  ysyx_22041752_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (exu_ent),
    .full (full),
    .empty(empty),
    .head (head)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we     <= 1'b0;
      rf_addr_w <= '0;
      rf_data_w <= '0;
      busy      <= '0;
    end else begin
      rf_we <= sel && win.rd != '0;
      if (sel) begin
        rf_addr_w <= win.rd;
        rf_data_w <= win.data;
      end
      busy <= busy_nxt;
    end
  end
  // A load may re-target the rd whose result is retiring in the same cycle; anything else busy is a decode bug.
  a_issue_busy: assert property (@(posedge clk) disable iff (rst)
    !(ld_issue && ld_issue_rd != '0 && busy[ld_issue_rd] && !(lsu_valid && lsu_rd == ld_issue_rd)));
  a_lsu_not_busy: assert property (@(posedge clk) disable iff (rst)
    !(lsu_valid && !busy[lsu_rd]));
endmodule

// File: tb/tb_ysyx_22041752_wb_arbiter.sv
// tb_ysyx_22041752_wb_arbiter: table-driven and sequence checks with an ordered write scoreboard
module tb_ysyx_22041752_wb_arbiter;
  logic        clk, rst;
  logic        exu_valid, exu_ready, exu_wen, lsu_valid, ld_issue, rf_we;
  logic [4:0]  exu_rd, lsu_rd, ld_issue_rd, rf_addr_w;
  logic [63:0] exu_data, lsu_data, rf_data_w;
  logic [31:0] busy;
  int n_chk = 0, n_fail = 0;
  typedef struct { logic [4:0] rd; logic [63:0] data; } wr_t;
  typedef struct { logic wen; logic [4:0] rd; logic [63:0] data; logic exp_we; } vec_t;
  wr_t  exp_q[$];
  vec_t tbl[5];
  ysyx_22041752_wb_arbiter #(.XLEN(64), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_wen(exu_wen), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .rf_we(rf_we), .rf_addr_w(rf_addr_w), .rf_data_w(rf_data_w), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    exu_valid = 0; exu_wen = 0; exu_rd = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    ld_issue = 0; ld_issue_rd = 0;
  endtask
  task automatic issue(input logic [4:0] rd);
    ld_issue = 1; ld_issue_rd = rd;
    step();
    idle();
  endtask
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got write rd=%0d data=%h, required no write", rf_addr_w, rf_data_w);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_addr_w !== e.rd || rf_data_w !== e.data) begin
          n_fail++;
          $display("FAIL wb_order: got rd=%0d data=%h required rd=%0d data=%h", rf_addr_w, rf_data_w, e.rd, e.data);
        end
      end
    end
  end
  initial begin
    tbl[0] = '{1'b1, 5'd5,  64'hDEAD_BEEF,          1'b1};
    tbl[1] = '{1'b1, 5'd0,  64'h1234,               1'b0};
    tbl[2] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    tbl[3] = '{1'b0, 5'd7,  64'h7777,               1'b0};
    tbl[4] = '{1'b1, 5'd1,  64'h8000_0000_0000_0001, 1'b1};
    idle();
    rst = 1; exu_valid = 1; exu_wen = 1; exu_rd = 2; exu_data = 64'h22;
    lsu_valid = 1; lsu_rd = 3; lsu_data = 64'h33;
    step(); step();
    rst = 0; idle();
    chk("rst_we", rf_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", exu_ready, 1);
    chk("rst_addr", rf_addr_w, 0);
    chk("rst_data", rf_data_w, 0);
    step();
    chk("rst_we_after", rf_we, 0);
    for (int i = 0; i < 5; i++) begin
      exu_valid = 1; exu_wen = tbl[i].wen; exu_rd = tbl[i].rd; exu_data = tbl[i].data;
      if (tbl[i].exp_we) exp_q.push_back('{tbl[i].rd, tbl[i].data});
      chk("tbl_ready", exu_ready, 1);
      step();
      idle();
      chk("tbl_we", rf_we, tbl[i].exp_we);
      if (tbl[i].exp_we) begin
        chk("tbl_addr", rf_addr_w, tbl[i].rd);
        chk("tbl_data", rf_data_w, tbl[i].data);
      end
      step();
      chk("tbl_we_once", rf_we, 0);
    end
    issue(5'd3);
    chk("cont_busy3", busy, 32'h8);
    lsu_valid = 1; lsu_rd = 3; lsu_data = 64'h1;
    exu_valid = 1; exu_wen = 1; exu_rd = 4; exu_data = 64'h2;
    exp_q.push_back('{5'd3, 64'h1});
    exp_q.push_back('{5'd4, 64'h2});
    chk("cont_ready_pre", exu_ready, 1);
    step();
    idle();
    chk("cont_we1", rf_we, 1);
    chk("cont_addr1", rf_addr_w, 3);
    chk("cont_ready_post", exu_ready, 1);
    chk("cont_busy_clr", busy, 0);
    step();
    chk("cont_we2", rf_we, 1);
    chk("cont_addr2", rf_addr_w, 4);
    chk("cont_data2", rf_data_w, 2);
    step();
    chk("cont_idle", rf_we, 0);
    for (int r = 10; r < 14; r++) issue(5'(r));
    for (int r = 10; r < 14; r++) exp_q.push_back('{5'(r), 64'(100 + r)});
    for (int r = 6; r < 9; r++) exp_q.push_back('{5'(r), 64'h600 + 64'(r)});
    begin
      int got = 0;
      for (int c = 0; c < 12 && got < 3; c++) begin
        lsu_valid = c < 4; lsu_rd = 5'(10 + c); lsu_data = 64'(110 + c);
        exu_valid = 1; exu_wen = 1; exu_rd = 5'(6 + got); exu_data = 64'h600 + 64'(6 + got);
        if (c >= 2 && c <= 4) chk("bp_ready_low", exu_ready, 0);
        if (exu_ready) got++;
        step();
      end
      idle();
      chk("bp_all_accepted", got, 3);
    end
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) step();
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_busy_clear", busy, 0);
    issue(5'd9);
    chk("sb_set9", busy, 32'h200);
    lsu_valid = 1; lsu_rd = 9; lsu_data = 64'h99;
    exp_q.push_back('{5'd9, 64'h99});
    step();
    idle();
    chk("sb_clr9", busy, 0);
    issue(5'd9);
    chk("sb_set9_again", busy, 32'h200);
    lsu_valid = 1; lsu_rd = 9; lsu_data = 64'h9A;
    ld_issue = 1; ld_issue_rd = 9;
    exp_q.push_back('{5'd9, 64'h9A});
    step();
    idle();
    chk("sb_set_wins", busy, 32'h200);
    chk("sb_we_same", rf_we, 1);
    lsu_valid = 1; lsu_rd = 9; lsu_data = 64'h9B;
    exp_q.push_back('{5'd9, 64'h9B});
    step();
    idle();
    chk("sb_final_clr", busy, 0);
    exu_valid = 1; exu_wen = 1; exu_rd = 0; exu_data = 64'hBAD;
    ld_issue = 1; ld_issue_rd = 0;
    chk("x0_ready_pre", exu_ready, 1);
    step();
    idle();
    chk("x0_we", rf_we, 0);
    chk("x0_busy", busy, 0);
    chk("x0_ready", exu_ready, 1);
    step();
    chk("x0_not_buffered", rf_we, 0);
    issue(5'd15);
    lsu_valid = 1; lsu_rd = 15; lsu_data = 64'hF0;
    exu_valid = 1; exu_wen = 1; exu_rd = 20; exu_data = 64'h20;
    step();
    idle();
    rst = 1;
    chk("mid_we_lsu", rf_we, 1);
    chk("mid_addr_lsu", rf_addr_w, 15);
    step();
    rst = 0;
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", exu_ready, 1);
    step();
    chk("mid_fifo_flushed", rf_we, 0);
    step();
    chk("mid_idle", rf_we, 0);
    chk("q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
